// File: rtl/mem_port_arbiter.sv
// Shares the main memory's data port between the MIPS CPU load/store path and
// the AXI-Lite host path using a request/grant handshake and 1-cycle read return.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  mips_cpu_clk,
  input  logic                  mips_cpu_reset,
  input  logic                  cpu_halt,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,

  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]           host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [31:0]           host_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,

  output logic [31:0]           conflict_cnt
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  // NOTE: every combinational output gets a default before the priority
  // chain, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!mips_cpu_reset) begin
      if (cpu_halt)
        host_gnt = host_req;
      else if (host_req && wait_cnt == WAIT_LIMIT)
        host_gnt = 1'b1;
      else if (cpu_req)
        cpu_gnt = 1'b1;
      else
        host_gnt = host_req;
    end
  end

  // Idle cycles drive zeros so the memory never sees stale address/data.
  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values of each other.
  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset)
      wait_cnt <= '0;
    else if (!host_req || host_gnt)
      wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIMIT)
      wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset) begin
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      cpu_rvalid  <= cpu_gnt & ~cpu_we;
      host_rvalid <= host_gnt & ~host_we;
    end
  end

  // Memory read data is shared; only the owner of the previous read sees it.
  assign cpu_rdata  = cpu_rvalid  ? mem_rdata : 32'h0;
  assign host_rdata = host_rvalid ? mem_rdata : 32'h0;

  always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
    if (mips_cpu_reset)
      conflict_cnt <= '0;
    else if (cpu_req && host_req && conflict_cnt != 32'hFFFF_FFFF)
      conflict_cnt <= conflict_cnt + 32'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for starvation, halt, mid-read reset and saturation.
module tb_mem_port_arbiter;

  logic        mips_cpu_clk = 1'b0;
  logic        mips_cpu_reset;
  logic        cpu_halt;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        host_req, host_we;
  logic [8:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] conflict_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 mips_cpu_clk = ~mips_cpu_clk;

  mem_port_arbiter #(.ADDR_WIDTH(9), .MAX_WAIT(15)) dut (
    .mips_cpu_clk  (mips_cpu_clk),
    .mips_cpu_reset(mips_cpu_reset),
    .cpu_halt      (cpu_halt),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_gnt       (cpu_gnt),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .conflict_cnt  (conflict_cnt)
  );

  typedef struct {
    logic        halt;
    logic        c_req;
    logic        c_we;
    logic [8:0]  c_addr;
    logic [31:0] c_wdata;
    logic        h_req;
    logic        h_we;
    logic [8:0]  h_addr;
    logic [31:0] h_wdata;
    logic [31:0] rdata;
    logic        e_cgnt;
    logic        e_hgnt;
    logic        e_en;
    logic        e_we;
    logic [8:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_hrv;
    logic [31:0] e_hrd;
    logic [31:0] e_conf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic halt, input logic c_req, input logic c_we,
                       input logic [8:0] c_addr, input logic [31:0] c_wdata,
                       input logic h_req, input logic h_we,
                       input logic [8:0] h_addr, input logic [31:0] h_wdata,
                       input logic [31:0] rdata);
    cpu_halt   = halt;
    cpu_req    = c_req;
    cpu_we     = c_we;
    cpu_addr   = c_addr;
    cpu_wdata  = c_wdata;
    host_req   = h_req;
    host_we    = h_we;
    host_addr  = h_addr;
    host_wdata = h_wdata;
    mem_rdata  = rdata;
  endtask

  task automatic idle(input logic [31:0] rdata);
    drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 32'hDEADBEEF,
                 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 9'h030, 32'h77, 1'b1, 1'b1, 9'h004, 32'h55, 32'h0,
                 1'b0, 1'b1, 1'b1, 1'b1, 9'h004, 32'h55, 1'b0, 32'h0, 1'b0, 32'h0, 32'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 9'h030, 32'h77, 1'b0, 1'b0, 9'h000, 32'h0, 32'h1234,
                 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 9'h030, 32'h77, 1'b0, 1'b0, 9'h000, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 9'h030, 32'h77, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 32'h99,
                 1'b1, 1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 9'h021, 32'h0, 32'hAAAA0020,
                 1'b0, 1'b1, 1'b1, 1'b0, 9'h021, 32'h0, 1'b1, 32'hAAAA0020, 1'b0, 32'h0, 32'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 32'hBBBB0021,
                 1'b1, 1'b0, 1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBBBB0021, 32'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0, 32'hCCCC0020,
                 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 32'hCCCC0020, 1'b0, 32'h0, 32'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 9'h040, 32'h1111, 1'b1, 1'b0, 9'h041, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b1, 9'h040, 32'h1111, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 9'h041, 32'h0, 32'h0,
                 1'b0, 1'b1, 1'b1, 1'b0, 9'h041, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd2};

    // Reset with both requesters active: nothing may reach the memory.
    mips_cpu_reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 1'b1, 1'b1, 9'h1FE, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (2) @(negedge mips_cpu_clk);
    #2;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_host_gnt", 32'(host_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    check("rst_conflict", conflict_cnt, 32'd0);
    @(negedge mips_cpu_clk);
    mips_cpu_reset = 1'b0;
    idle(32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge mips_cpu_clk);
      drive(vecs[i].halt, vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
            vecs[i].h_req, vecs[i].h_we, vecs[i].h_addr, vecs[i].h_wdata, vecs[i].rdata);
      #2;
      check($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].e_cgnt));
      check($sformatf("v%0d_host_gnt", i), 32'(host_gnt), 32'(vecs[i].e_hgnt));
      check($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_crv));
      check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      check($sformatf("v%0d_host_rvalid", i), 32'(host_rvalid), 32'(vecs[i].e_hrv));
      check($sformatf("v%0d_host_rdata", i), host_rdata, vecs[i].e_hrd);
      check($sformatf("v%0d_conflict", i), conflict_cnt, vecs[i].e_conf);
    end

    // Starvation: CPU hammers the port; the host breaks through on its 16th cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge mips_cpu_clk);
      drive(1'b0, 1'b1, 1'b0, 9'h100, 32'h0, 1'b1, 1'b0, 9'h101, 32'h0, 32'h0);
      #2;
      check($sformatf("starve%0d_cpu_gnt", i), 32'(cpu_gnt), (i < 15) ? 32'd1 : 32'd0);
      check($sformatf("starve%0d_host_gnt", i), 32'(host_gnt), (i == 15) ? 32'd1 : 32'd0);
    end
    check("starve_mem_addr", 32'(mem_addr), 32'h101);
    @(negedge mips_cpu_clk);
    idle(32'hFEED0101);
    #2;
    check("starve_host_rvalid", 32'(host_rvalid), 32'd1);
    check("starve_host_rdata", host_rdata, 32'hFEED0101);
    check("starve_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("starve_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    check("starve_conflict", conflict_cnt, 32'd18);

    // Halt rising over a pending CPU request holds it until halt falls.
    for (int i = 0; i < 3; i++) begin
      @(negedge mips_cpu_clk);
      drive(1'b1, 1'b1, 1'b0, 9'h0AA, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
      #2;
      check($sformatf("halt%0d_cpu_gnt", i), 32'(cpu_gnt), 32'd0);
      check($sformatf("halt%0d_mem_en", i), 32'(mem_en), 32'd0);
    end
    @(negedge mips_cpu_clk);
    drive(1'b0, 1'b1, 1'b0, 9'h0AA, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    #2;
    check("unhalt_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("unhalt_mem_addr", 32'(mem_addr), 32'h0AA);

    // Reset right after a host read grant drops the pending return.
    @(negedge mips_cpu_clk);
    drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h0BB, 32'h0, 32'h0);
    #2;
    check("rstrd_host_gnt", 32'(host_gnt), 32'd1);
    @(posedge mips_cpu_clk);
    #1;
    mips_cpu_reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h0BB, 32'h0, 32'hBAD0BAD0);
    #1;
    check("rstrd_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rstrd_host_rdata", host_rdata, 32'h0);
    check("rstrd_host_gnt_in_rst", 32'(host_gnt), 32'd0);
    @(negedge mips_cpu_clk);
    mips_cpu_reset = 1'b0;
    idle(32'hBAD0BAD0);
    @(negedge mips_cpu_clk);
    #2;
    check("rstrd_rvalid_after", 32'(host_rvalid), 32'd0);
    check("rstrd_conflict", conflict_cnt, 32'd0);
    check("rstrd_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b0, 9'h0BC, 32'h0, 32'h0);
    #1;
    check("rstrd_next_gnt", 32'(host_gnt), 32'd1);
    @(negedge mips_cpu_clk);
    idle(32'h0BC0DA7A);
    #2;
    check("rstrd_next_rvalid", 32'(host_rvalid), 32'd1);
    check("rstrd_next_rdata", host_rdata, 32'h0BC0DA7A);

    // Counter saturation: preload near the top, then keep both sides requesting.
    @(negedge mips_cpu_clk);
    force dut.conflict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.conflict_cnt;
    drive(1'b0, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 1'b0, 9'h002, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge mips_cpu_clk);
      #2;
      check($sformatf("sat%0d_conflict", i), conflict_cnt, 32'hFFFF_FFFF);
    end
    idle(32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
